// File: rtl/lpc_io_target_if.sv
// lpc_io_target_if: backend access bus between the LPC I/O target and its register block
interface lpc_io_target_if;
  logic        bus_req;
  logic        bus_wr;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_ack;
  modport master(output bus_req, bus_wr, bus_addr, bus_wdata, input bus_rdata, bus_ack);
  modport slave(input bus_req, bus_wr, bus_addr, bus_wdata, output bus_rdata, bus_ack);
endinterface

// File: rtl/lpc_io_target.sv
// lpc_io_target: LPC I/O read/write target bridging decoded cycles onto a req/ack backend bus
module lpc_io_target #(
  parameter logic [15:0] BASE_ADDR = 16'h0060,
  parameter logic [15:0] ADDR_MASK = 16'hFFF0,
  parameter int          MAX_WAIT  = 32
) (
  input  logic             lclk,
  input  logic             lreset_n,
  input  logic             lframe_n,
  inout  wire  [3:0]       lad,
  output logic             busy,
  lpc_io_target_if.master  bus
);
  typedef enum logic [4:0] {
    IDLE, START, CTDIR, ADDR0, ADDR1, ADDR2, ADDR3, WDAT0, WDAT1, TAR1, TAR2,
    SYNC_WAIT, SYNC_OK, SYNC_ERR, RDAT0, RDAT1, PTAR
  } state_e;
  state_e      state_q, state_d;
  logic        req_q, req_d, wr_q, wr_d, lad_oe, hit;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d, rdata_q, rdata_d, cnt_q, cnt_d;
  logic [3:0]  lad_out;
  assign hit = (addr_q & ADDR_MASK) == (BASE_ADDR & ADDR_MASK);
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    // a new frame pre-empts whatever cycle is in flight
    if (!lframe_n && state_q != START) begin
      state_d = (lad == 4'h0) ? START : IDLE;
      req_d   = 1'b0;
    end else begin
      case (state_q)
        START: if (lframe_n) begin
          state_d = (lad == 4'h0 || lad == 4'h2) ? ADDR0 : IDLE;
          wr_d    = (lad == 4'h0 || lad == 4'h2) ? lad[1] : wr_q;
        end else if (lad != 4'h0) state_d = IDLE;
        ADDR0: begin addr_d[15:12] = lad; state_d = ADDR1; end
        ADDR1: begin addr_d[11:8]  = lad; state_d = ADDR2; end
        ADDR2: begin addr_d[7:4]   = lad; state_d = ADDR3; end
        ADDR3: begin addr_d[3:0]   = lad; state_d = wr_q ? WDAT0 : TAR1; end
        WDAT0: begin wdata_d[3:0]  = lad; state_d = WDAT1; end
        WDAT1: begin wdata_d[7:4]  = lad; state_d = TAR1; end
        TAR1: begin
          state_d = (lad == 4'hF && hit) ? TAR2 : IDLE;
          req_d   = lad == 4'hF && hit;
        end
        TAR2: begin
          state_d = SYNC_WAIT;
          cnt_d   = 8'd1;
          req_d   = !bus.bus_ack;
          rdata_d = (bus.bus_ack && !wr_q) ? bus.bus_rdata : rdata_q;
        end
        // req already low here means the ack was taken during TAR2
        SYNC_WAIT: if (bus.bus_ack || !req_q) begin
          state_d = SYNC_OK;
          req_d   = 1'b0;
          rdata_d = (req_q && !wr_q) ? bus.bus_rdata : rdata_q;
        end else if (cnt_q == 8'(MAX_WAIT)) begin
          state_d = SYNC_ERR;
          req_d   = 1'b0;
          rdata_d = 8'hFF;
        end else cnt_d = cnt_q + 8'd1;
        SYNC_OK, SYNC_ERR: state_d = wr_q ? PTAR : RDAT0;
        RDAT0: state_d = RDAT1;
        RDAT1: state_d = PTAR;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0;
      wdata_q <= 8'h0;
      rdata_q <= 8'h0;
      cnt_q   <= 8'h0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    lad_oe  = state_q inside {SYNC_WAIT, SYNC_OK, SYNC_ERR, RDAT0, RDAT1, PTAR};
    lad_out = state_q == SYNC_WAIT ? 4'h6 :
              state_q == SYNC_ERR  ? 4'hA :
              state_q == RDAT0     ? rdata_q[3:0] :
              state_q == RDAT1     ? rdata_q[7:4] :
              state_q == PTAR      ? 4'hF : 4'h0;
  end
  assign lad           = lad_oe ? lad_out : 4'bzzzz;
  assign busy          = state_q != IDLE;
  assign bus.bus_req   = req_q;
  assign bus.bus_wr    = wr_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;
endmodule

// File: doc/lpc_io_target.md
LPC_IO_TARGET -- requirements
Module: lpc_io_target

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0060, meaning the I/O decode base address.
REQ-002 SHALL have parameter ADDR_MASK, default 16'hFFF0, meaning the compared address bits (1 = compare).
REQ-003 SHALL have parameter MAX_WAIT, default 32, meaning the long-wait SYNC clocks allowed before error SYNC; legal range 1..255.
REQ-004 SHALL have port lclk, input, 1, LPC clock; all logic on its rising edge.
REQ-005 SHALL have port lreset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port lframe_n, input, 1, LPC frame, active low.
REQ-007 SHALL have port lad, inout, 4, LPC address/data bus; the block drives it only when the internal lad_oe is 1, else 4'bzzzz.
REQ-008 SHALL have port bus_req, output, 1, backend access request.
REQ-009 SHALL have port bus_wr, output, 1, backend access type: 1 = write, 0 = read.
REQ-010 SHALL have port bus_addr, output, 16, captured LPC I/O address.
REQ-011 SHALL have port bus_wdata, output, 8, captured write data.
REQ-012 SHALL have port bus_rdata, input, 8, backend read data, valid when bus_ack = 1.
REQ-013 SHALL have port bus_ack, input, 1, backend completion.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 States SHALL be: IDLE, START, CTDIR, ADDR0..ADDR3, WDAT0, WDAT1, TAR1, TAR2, SYNC_WAIT, SYNC_OK, SYNC_ERR, RDAT0, RDAT1, PTAR.
REQ-016 IDLE/any state SHALL go to START when lframe_n = 0 and lad = 4'h0; START SHALL remain while lframe_n = 0 and lad = 4'h0.
REQ-017 START SHALL go to ADDR0 when lframe_n = 1 and lad = 4'h0 (read, bus_wr=0) or lad = 4'h2 (write, bus_wr=1); any other value SHALL return to IDLE.
REQ-018 ADDR0..ADDR3 SHALL capture bus_addr[15:12], [11:8], [7:4], [3:0] in order, one nibble per clock.
REQ-019 Write cycles SHALL then capture bus_wdata[3:0] (WDAT0) then bus_wdata[7:4] (WDAT1); read cycles SHALL go from ADDR3 directly to TAR1.
REQ-020 TAR1 SHALL require lad = 4'hF, else go to IDLE; TAR2 SHALL ignore lad.
REQ-021 Decode hit SHALL be (bus_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK), evaluated in TAR1; on miss the block SHALL go to IDLE at the end of TAR1, never drive lad, and never assert bus_req.
REQ-022 On hit, bus_req SHALL rise on the clock edge leaving TAR1 and stay high until the edge after bus_ack is sampled 1, or until timeout/abort.
REQ-023 SYNC_WAIT SHALL drive lad = 4'h6 each clock with a wait counter starting at 1; when bus_ack = 1 is sampled, the next clock SHALL be SYNC_OK with lad = 4'h0; a read SHALL latch bus_rdata on that sample.
REQ-024 If the counter reaches MAX_WAIT with bus_ack = 0, the next clock SHALL be SYNC_ERR with lad = 4'hA, bus_req SHALL drop, and the latched read data SHALL become 8'hFF; a later bus_ack SHALL be ignored.
REQ-025 A bus_ack already high in TAR2 SHALL be accepted and give exactly one SYNC_WAIT clock.
REQ-026 Read: SYNC_OK/SYNC_ERR SHALL be followed by RDAT0 (data[3:0]) then RDAT1 (data[7:4]), then PTAR; write: SYNC_OK/SYNC_ERR SHALL be followed directly by PTAR.
REQ-027 PTAR SHALL drive lad = 4'hF for one clock, then release lad and go to IDLE.
REQ-028 lad_oe SHALL be 1 only in SYNC_WAIT, SYNC_OK, SYNC_ERR, RDAT0, RDAT1 and PTAR.
REQ-029 lframe_n = 0 sampled in any state from CTDIR through PTAR SHALL abort: at that edge lad_oe and bus_req SHALL go to 0, and the next state SHALL be START if lad = 4'h0, else IDLE.
REQ-030 bus_addr, bus_wdata and bus_wr SHALL hold their values from capture until the next START.

Reset
REQ-031 While lreset_n = 0, the following SHALL hold: state IDLE, bus_req=0, bus_wr=0, bus_addr=16'h0, bus_wdata=8'h0, busy=0, lad_oe=0 (lad high-Z), wait counter 0, read-data latch 8'h0.
REQ-032 Reset asserted mid-cycle SHALL release lad and bus_req asynchronously; after reset release the block SHALL wait for a new START.

Verification
REQ-033 I/O read 0x0064, bus_ack 3 clocks after bus_req, bus_rdata=8'hA5 -> lad: 6,6,6,0,5,A,F, then Z; bus_req high for exactly 4 clocks.
REQ-034 I/O write 0x0061 data 8'h3C, immediate ack -> bus_wr=1, bus_wdata=8'h3C, bus_addr=16'h0061; lad: 6,0,F.
REQ-035 I/O read 0x0080 (decode miss) -> lad never driven, bus_req stays 0, busy=0 one clock after TAR1.
REQ-036 Read to 0x0060 with MAX_WAIT=4 and no ack -> four 4'h6 clocks, then A,F,F,F; bus_req falls with SYNC_ERR; a later ack has no effect.
REQ-037 lframe_n=0 with lad=4'h0 during SYNC_WAIT -> lad released and bus_req=0 on that edge, state START, and the following cycle decodes normally.
REQ-038 lreset_n pulsed low during RDAT0 -> lad high-Z immediately, all outputs at reset values, and the next complete read succeeds.
